switch_debouncer: RTL and testbench

- Upstream input-conditioning stage for the rotating-LED jackpot game. Takes the four raw, bouncing board switches and produces clean per-switch levels, one-cycle edge pulses, a one-hot qualifier, and a press-event register with valid/ack handshake.
- The game logic samples these clean outputs instead of the raw pins, so asynchronous, multi-bit-glitchy switch values never reach the match comparison.

---
 rtl/switch_debouncer_pkg.sv | 11 +
 rtl/switch_debouncer_channel.sv | 74 +++++++
 rtl/switch_debouncer.sv | 92 +++++++++
 tb/tb_switch_debouncer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared timing constants for the jackpot game input path.
// Switch count, debounce window and board clock frequency.
package switch_debouncer_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned N_DEF = 4;
  // 20 ms at the board clock
  localparam int unsigned DEBOUNCE_CYCLES_DEF =
    CLK_HZ / 50;

endpackage

// File: rtl/switch_debouncer_channel.sv
// One switch channel: 2-flop sync, debounce counter,
// stable level, rise/fall pulses.
// Ports:
//   clk, rst    clock, async active-high reset
//   raw_i       raw pin
//   stable_o    debounced level
//   rise_o      1-cycle pulse on stable 0->1
//   fall_o      1-cycle pulse on stable 1->0
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES =
    DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W =
    $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic s1_q;
  logic s2_q;
  logic stable_q, stable_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s2_q;
      cnt_d    = '0;
      rise_d   = s2_q;
      fall_d   = ~s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the game switches and captures press events
// behind a valid/ack handshake with a sticky overrun flag.
// Ports:
//   clk, rst     clock, async active-high reset
//   sw_raw       raw switch pins
//   sw_stable    debounced levels
//   sw_rise/fall 1-cycle edge pulses per channel
//   sw_onehot    exactly one stable switch set
//   evt_valid    press event held in evt_data
//   evt_data     sw_stable snapshot at the press
//   evt_ack      consumer acknowledge
//   evt_overrun  sticky: a press event was dropped
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned DEBOUNCE_CYCLES =
    DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W =
    $clog2(DEBOUNCE_CYCLES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] sw_stable,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall,
  output logic         sw_onehot,
  output logic         evt_valid,
  output logic [N-1:0] evt_data,
  input  logic         evt_ack,
  output logic         evt_overrun
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (sw_raw[i]),
      .stable_o(sw_stable[i]),
      .rise_o  (sw_rise[i]),
      .fall_o  (sw_fall[i])
    );
  end

  assign sw_onehot = ($countones(sw_stable) == 1);

  logic         valid_q, valid_d;
  logic [N-1:0] data_q, data_d;
  logic         ovr_q, ovr_d;
  logic         press;

  assign press = |sw_rise;

  // An ack coinciding with a new press frees the slot,
  // so the new press is taken rather than dropped.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if (press) begin
      if (!valid_q || evt_ack) begin
        valid_d = 1'b1;
        data_d  = sw_stable;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (evt_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign evt_valid   = valid_q;
  assign evt_data    = data_q;
  assign evt_overrun = ovr_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Random bouncing-switch stimulus against a sliding-window
// reference model of the debouncer and event handshake.
module tb_switch_debouncer;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw_raw = '1;
  logic [N-1:0] sw_stable, sw_rise, sw_fall;
  logic         sw_onehot;
  logic         evt_valid;
  logic [N-1:0] evt_data;
  logic         evt_ack = 1'b0;
  logic         evt_overrun;

  switch_debouncer #(
    .N              (N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .sw_stable  (sw_stable),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_onehot  (sw_onehot),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .evt_ack    (evt_ack),
    .evt_overrun(evt_overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: raw samples per edge; the synchronizer
  // delays them by two edges, and a channel flips once
  // the last D synchronized samples all disagree with it.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_stable = '0;
  logic [N-1:0] m_rise = '0;
  logic [N-1:0] m_fall = '0;
  logic [N-1:0] m_data = '0;
  logic         m_valid = 1'b0;
  logic         m_ovr = 1'b0;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++)
      hist.push_back('0);
    m_stable = '0;
    m_rise   = '0;
    m_fall   = '0;
    m_data   = '0;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      logic [N-1:0] ns, nr, nf, smp;
      logic all_diff;
      if (|m_rise) begin
        if (!m_valid || evt_ack) begin
          m_valid = 1'b1;
          m_data  = m_stable;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (evt_ack) begin
        m_valid = 1'b0;
      end
      hist.push_back(sw_raw);
      void'(hist.pop_front());
      ns = m_stable;
      nr = '0;
      nf = '0;
      for (int c = 0; c < N; c++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) begin
          smp = hist[k];
          if (smp[c] == m_stable[c]) all_diff = 1'b0;
        end
        if (all_diff) begin
          ns[c] = ~m_stable[c];
          nr[c] = ~m_stable[c];
          nf[c] = m_stable[c];
        end
      end
      m_stable = ns;
      m_rise   = nr;
      m_fall   = nf;
    end
  end

  task automatic check_all();
    chk("stable", 32'(sw_stable), 32'(m_stable));
    chk("rise", 32'(sw_rise), 32'(m_rise));
    chk("fall", 32'(sw_fall), 32'(m_fall));
    chk("onehot", 32'(sw_onehot),
        32'($countones(m_stable) == 1));
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    chk("evt_data", 32'(evt_data), 32'(m_data));
    chk("overrun", 32'(evt_overrun), 32'(m_ovr));
  endtask

  logic [N-1:0] level = '1;
  int bnc[N];
  int rst_left = 0;

  initial begin
    for (int c = 0; c < N; c++) bnc[c] = 0;
    // Reset held with all switches closed
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check_all();
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 24) == 0) begin
          level[c] = ~level[c];
          bnc[c] = $urandom_range(0, 8);
        end
        if (bnc[c] > 0) begin
          bnc[c]--;
          sw_raw[c] = 1'($urandom_range(0, 1));
        end else begin
          sw_raw[c] = level[c];
        end
      end
      evt_ack = ($urandom_range(0, 9) < 2);
      if (rst_left > 0) begin
        rst_left--;
        rst = (rst_left > 0);
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        rst_left = $urandom_range(1, 3);
      end
    end
    @(negedge clk);
    check_all();
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
